// File: rtl/npu_pkg.sv
// Shared NPU definitions used by the compute-unit sequencer.
//   CU_PE_NUM / CU_LEN_W : default PE count and length-field width
//   cu_seq_state_t       : sequencer FSM states
//   cu_job_t             : job descriptor layout (mac_len, out_num, bias_en, pe_mask)
package npu_pkg;

  localparam int CU_PE_NUM = 8;
  localparam int CU_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FLUSH       = 3'd1,
    BIAS        = 3'd2,
    MAC         = 3'd3,
    OUT         = 3'd4,
    FLUSH_ABORT = 3'd5,
    DONE        = 3'd6
  } cu_seq_state_t;

  typedef struct packed {
    logic [CU_LEN_W-1:0]  mac_len;
    logic [CU_LEN_W-1:0]  out_num;
    logic                 bias_en;
    logic [CU_PE_NUM-1:0] pe_mask;
  } cu_job_t;

endpackage

// File: rtl/cu_seq_ctrl.sv
// Compute-unit sequencer. Takes one job descriptor per layer tile and drives
// the per-PE control vectors so every active PE produces out_num results, each
// made of an optional bias load followed by mac_len MACs.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid/cfg_ready      descriptor handshake (ready only in IDLE)
//   cfg_mac_len/out_num/bias_en/pe_mask   descriptor fields
//   abort                    kill the running job (flush, then done)
//   op_valid/op_ready        operand-set stream from the operand buffers
//   pe_in_valid/pe_calc_bias/pe_out_en/pe_flush   CU control
//   pe_illegal_uop           per-PE illegal-uop flags from the CU
//   busy, done, err, out_cnt status to the layer controller
module cu_seq_ctrl
  import npu_pkg::*;
#(
  parameter int PE_NUM = CU_PE_NUM,
  parameter int LEN_W  = CU_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LEN_W-1:0]  cfg_mac_len,
  input  logic [LEN_W-1:0]  cfg_out_num,
  input  logic              cfg_bias_en,
  input  logic [PE_NUM-1:0] cfg_pe_mask,
  input  logic              abort,
  input  logic              op_valid,
  output logic              op_ready,
  output logic [PE_NUM-1:0] pe_in_valid,
  output logic [PE_NUM-1:0] pe_calc_bias,
  output logic [PE_NUM-1:0] pe_out_en,
  output logic              pe_flush,
  input  logic [PE_NUM-1:0] pe_illegal_uop,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  out_cnt
);

  cu_seq_state_t     r_state;
  cu_seq_state_t     w_state_nxt;
  logic [LEN_W-1:0]  r_mac_len;
  logic [LEN_W-1:0]  r_out_num;
  logic              r_bias_en;
  logic [PE_NUM-1:0] r_mask;
  logic [LEN_W-1:0]  r_mac_cnt;
  logic [LEN_W-1:0]  r_out_cnt;
  logic              r_err;

  logic w_accept;
  logic w_abort;
  logic w_hs;
  logic w_mac_last;
  logic w_out_last;
  logic w_mac_zero;

  assign w_accept   = cfg_valid && (r_state == IDLE);
  // Abort is only honoured in the working states; FLUSH_ABORT and DONE are
  // already on their way out and IDLE has nothing to kill.
  assign w_abort    = abort && ((r_state == FLUSH) || (r_state == BIAS) ||
                                (r_state == MAC)   || (r_state == OUT));
  assign w_hs       = op_valid && op_ready;
  // mac_len is non-zero whenever MAC is entered, so mac_len-1 cannot wrap here.
  assign w_mac_last = (r_mac_cnt == (r_mac_len - LEN_W'(1)));
  assign w_out_last = ((r_out_cnt + LEN_W'(1)) == r_out_num);
  assign w_mac_zero = (r_mac_len == '0);

  always_comb begin
    w_state_nxt  = r_state;
    cfg_ready    = 1'b0;
    op_ready     = 1'b0;
    pe_in_valid  = '0;
    pe_calc_bias = '0;
    pe_out_en    = '0;
    pe_flush     = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        pe_flush = 1'b1;
        if (r_out_num == '0)  w_state_nxt = DONE;
        else if (r_bias_en)   w_state_nxt = BIAS;
        else if (w_mac_zero)  w_state_nxt = OUT;
        else                  w_state_nxt = MAC;
      end
      BIAS: begin
        op_ready = 1'b1;
        if (op_valid) begin
          pe_in_valid  = r_mask;
          pe_calc_bias = r_mask;
          w_state_nxt  = w_mac_zero ? OUT : MAC;
        end
      end
      MAC: begin
        op_ready = 1'b1;
        if (op_valid) begin
          pe_in_valid = r_mask;
          if (w_mac_last) w_state_nxt = OUT;
        end
      end
      OUT: begin
        pe_out_en = r_mask;
        if (w_out_last)      w_state_nxt = DONE;
        else if (r_bias_en)  w_state_nxt = BIAS;
        else if (w_mac_zero) w_state_nxt = OUT;
        else                 w_state_nxt = MAC;
      end
      FLUSH_ABORT: begin
        pe_flush    = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Abort wins over a same-cycle operand handshake: nothing is consumed.
    if (w_abort) begin
      w_state_nxt  = FLUSH_ABORT;
      op_ready     = 1'b0;
      pe_in_valid  = '0;
      pe_calc_bias = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mac_len <= '0;
      r_out_num <= '0;
      r_bias_en <= 1'b0;
      r_mask    <= '0;
      r_mac_cnt <= '0;
      r_out_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mac_len <= cfg_mac_len;
        r_out_num <= cfg_out_num;
        r_bias_en <= cfg_bias_en;
        r_mask    <= cfg_pe_mask;
        r_mac_cnt <= '0;
        r_out_cnt <= '0;
        r_err     <= 1'b0;
      end else begin
        if ((r_state == MAC) && w_hs)
          r_mac_cnt <= w_mac_last ? '0 : (r_mac_cnt + LEN_W'(1));
        // An output whose OUT cycle was reached is complete even if aborted.
        if (r_state == OUT)
          r_out_cnt <= r_out_cnt + LEN_W'(1);
        if (r_state != IDLE)
          r_err <= r_err | (|(pe_illegal_uop & r_mask));
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign err     = r_err;
  assign out_cnt = r_out_cnt;

endmodule

// File: tb/tb_cu_seq_ctrl.sv
module tb_cu_seq_ctrl;
  import npu_pkg::*;

  localparam int PE = 8;
  localparam int LW = 16;

  logic          clk;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [LW-1:0] cfg_mac_len;
  logic [LW-1:0] cfg_out_num;
  logic          cfg_bias_en;
  logic [PE-1:0] cfg_pe_mask;
  logic          abort;
  logic          op_valid;
  logic          op_ready;
  logic [PE-1:0] pe_in_valid;
  logic [PE-1:0] pe_calc_bias;
  logic [PE-1:0] pe_out_en;
  logic          pe_flush;
  logic [PE-1:0] pe_illegal_uop;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] out_cnt;

  cu_seq_ctrl #(.PE_NUM(PE), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mac_len(cfg_mac_len), .cfg_out_num(cfg_out_num),
    .cfg_bias_en(cfg_bias_en), .cfg_pe_mask(cfg_pe_mask),
    .abort(abort), .op_valid(op_valid), .op_ready(op_ready),
    .pe_in_valid(pe_in_valid), .pe_calc_bias(pe_calc_bias),
    .pe_out_en(pe_out_en), .pe_flush(pe_flush),
    .pe_illegal_uop(pe_illegal_uop),
    .busy(busy), .done(done), .err(err), .out_cnt(out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Results of the last run_job
  int          r_done_cyc;
  int          r_hs;
  int          r_outen;
  int          r_bias;
  int          r_flush;
  logic [63:0] r_outen_map;
  logic [63:0] r_hs_map;
  logic        r_err_done;
  int          r_outcnt_done;
  bit          r_inv_ok;

  // mode 0: op_valid held high; mode 1: op_valid high on odd cycles only.
  task automatic run_job(input int mac, input int outn, input bit bias,
                         input logic [7:0] mask, input int mode,
                         input int abort_cyc, input int ill_cyc, input int ill_bit);
    logic hs;
    r_done_cyc = -1; r_hs = 0; r_outen = 0; r_bias = 0; r_flush = 0;
    r_outen_map = '0; r_hs_map = '0; r_err_done = 1'bx; r_outcnt_done = -1;
    r_inv_ok = 1'b1;
    @(posedge clk); #1;
    cfg_mac_len = LW'(mac);
    cfg_out_num = LW'(outn);
    cfg_bias_en = bias;
    cfg_pe_mask = mask;
    cfg_valid   = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      op_valid       = (mode == 0) ? 1'b1 : 1'((cyc % 2) == 1);
      abort          = (cyc == abort_cyc);
      pe_illegal_uop = (cyc == ill_cyc) ? (8'b1 << ill_bit) : 8'h00;
      #2;
      hs = op_valid & op_ready;
      if (hs) begin
        r_hs++;
        if (cyc < 64) r_hs_map[cyc] = 1'b1;
      end
      if (|pe_out_en) begin
        r_outen++;
        if (cyc < 64) r_outen_map[cyc] = 1'b1;
      end
      if (|pe_calc_bias) r_bias++;
      if (pe_flush) r_flush++;
      if (pe_in_valid !== (hs ? mask : 8'h00)) r_inv_ok = 1'b0;
      if (((pe_calc_bias | pe_out_en) & ~mask) != 8'h00) r_inv_ok = 1'b0;
      if ((pe_calc_bias & ~pe_in_valid) != 8'h00) r_inv_ok = 1'b0;
      if ((|pe_out_en) && (|pe_in_valid)) r_inv_ok = 1'b0;
      if (pe_out_en !== 8'h00 && pe_out_en !== mask) r_inv_ok = 1'b0;
      if (done) begin
        r_done_cyc    = cyc;
        r_err_done    = err;
        r_outcnt_done = int'(out_cnt);
        break;
      end
      @(posedge clk); #1;
    end
    op_valid       = 1'b0;
    abort          = 1'b0;
    pe_illegal_uop = '0;
  endtask

  typedef struct {
    int         mac;
    int         outn;
    bit         bias;
    logic [7:0] mask;
    int         exp_done;
    int         exp_hs;
    int         exp_outen;
    int         exp_bias;
  } vec_t;

  vec_t tbl[5];

  initial begin
    cfg_valid = 0; cfg_mac_len = '0; cfg_out_num = '0; cfg_bias_en = 0;
    cfg_pe_mask = '0; abort = 0; op_valid = 0; pe_illegal_uop = '0;
    rst = 1'b1;

    // done cycle = 1 + outn*(bias+mac+1) + 1; handshakes = outn*(bias+mac)
    tbl[0] = '{3, 2, 1'b1, 8'hFF, 12, 8, 2, 2};
    tbl[1] = '{1, 4, 1'b0, 8'h0F, 10, 4, 4, 0};
    tbl[2] = '{3, 0, 1'b1, 8'hFF,  2, 0, 0, 0};
    tbl[3] = '{0, 1, 1'b1, 8'hFF,  4, 1, 1, 1};
    tbl[4] = '{2, 3, 1'b0, 8'hA5, 11, 6, 3, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_done",      64'(done), 64'd0);
    chk("rst_err",       64'(err), 64'd0);
    chk("rst_out_cnt",   64'(out_cnt), 64'd0);
    chk("rst_pe",        64'({pe_in_valid, pe_calc_bias, pe_out_en, pe_flush, op_ready}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_job(tbl[i].mac, tbl[i].outn, tbl[i].bias, tbl[i].mask, 0, 0, 0, 0);
      chk($sformatf("tbl%0d_done_cyc", i), 64'(r_done_cyc), 64'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_hs", i),       64'(r_hs), 64'(tbl[i].exp_hs));
      chk($sformatf("tbl%0d_out_en", i),   64'(r_outen), 64'(tbl[i].exp_outen));
      chk($sformatf("tbl%0d_bias", i),     64'(r_bias), 64'(tbl[i].exp_bias));
      chk($sformatf("tbl%0d_flush", i),    64'(r_flush), 64'd1);
      chk($sformatf("tbl%0d_out_cnt", i),  64'(r_outcnt_done), 64'(tbl[i].outn));
      chk($sformatf("tbl%0d_err", i),      64'(r_err_done), 64'd0);
      chk($sformatf("tbl%0d_pe_vectors", i), 64'(r_inv_ok), 64'd1);
    end

    // Exact cycle placement: F B M M M O B M M M O D
    run_job(3, 2, 1'b1, 8'hFF, 0, 0, 0, 0);
    chk("seq_hs_map",    r_hs_map, 64'h7BC);
    chk("seq_outen_map", r_outen_map, 64'h840);

    // op_valid toggling: stalls on even cycles
    run_job(3, 2, 1'b1, 8'hFF, 1, 0, 0, 0);
    chk("tog_done_cyc",   64'(r_done_cyc), 64'd19);
    chk("tog_hs",         64'(r_hs), 64'd8);
    chk("tog_hs_map",     r_hs_map, 64'h2AAA8);
    chk("tog_outen_map",  r_outen_map, 64'h40400);
    chk("tog_pe_vectors", 64'(r_inv_ok), 64'd1);

    // Abort during the 2nd MAC of the first output (cycle 4)
    run_job(3, 2, 1'b1, 8'hFF, 0, 4, 0, 0);
    chk("abort_done_cyc", 64'(r_done_cyc), 64'd6);
    chk("abort_hs_map",   r_hs_map, 64'hC);
    chk("abort_flush",    64'(r_flush), 64'd2);
    chk("abort_out_en",   64'(r_outen), 64'd0);
    chk("abort_out_cnt",  64'(r_outcnt_done), 64'd0);
    @(posedge clk); #1;
    chk("abort_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("abort_busy",      64'(busy), 64'd0);

    // Illegal uop on an active PE is sticky through done and into IDLE
    run_job(3, 2, 1'b1, 8'hFF, 0, 0, 4, 2);
    chk("ill_err_done", 64'(r_err_done), 64'd1);
    @(posedge clk); #1;
    chk("ill_err_idle", 64'(err), 64'd1);

    // Same pulse on a masked PE: accept clears err and it stays clear
    run_job(3, 2, 1'b1, 8'hFB, 0, 0, 4, 2);
    chk("ill_masked_err",  64'(r_err_done), 64'd0);
    chk("ill_masked_done", 64'(r_done_cyc), 64'd12);

    // Reset in the middle of a job
    @(posedge clk); #1;
    cfg_mac_len = 16'd3; cfg_out_num = 16'd2; cfg_bias_en = 1'b1;
    cfg_pe_mask = 8'hFF; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    op_valid  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy",      64'(busy), 64'd0);
    chk("midrst_pe",        64'({pe_in_valid, pe_calc_bias, pe_out_en, pe_flush, op_ready, done}), 64'd0);
    chk("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(1, 1, 1'b0, 8'hFF, 0, 0, 0, 0);
    chk("post_rst_done_cyc", 64'(r_done_cyc), 64'd4);
    chk("post_rst_out_cnt",  64'(r_outcnt_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
